// File: rtl/stroke_painter.sv
// Square-brush rasterizer and full-screen clear engine feeding the framebuffer write port.
// Each pixel is one valid/ready write (fb_addr_out = y*H_RES + x); a stroke or clear ends with a one-cycle stroke_done_out.
module stroke_painter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 360,
    parameter int ADDR_W = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [9:0]        cursor_loc_x,
    input  logic [8:0]        cursor_loc_y,
    input  logic [3:0]        cursor_color,
    input  logic [2:0]        stroke_width,
    input  logic              pen_down_in,
    input  logic              clear_in,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [3:0]        fb_data_out,
    output logic              fb_valid_out,
    input  logic              fb_ready_in,
    output logic              busy_out,
    output logic              stroke_done_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [9:0]        X_MAX     = 10'(H_RES - 1);
    localparam logic [8:0]        Y_MAX     = 9'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic [1:0]        state;
    logic [9:0]        snap_x;
    logic [8:0]        snap_y;
    logic [3:0]        snap_color;
    logic [2:0]        snap_w;
    logic              snap_valid;
    logic              clear_pending;
    logic [9:0]        box_x0;
    logic [9:0]        box_x1;
    logic [8:0]        box_y1;
    logic [9:0]        cur_x;
    logic [8:0]        cur_y;
    logic [ADDR_W-1:0] row_base;

    logic [9:0]        clamp_x, wide_x, sum_x, lo_x, hi_x;
    logic [8:0]        clamp_y, wide_y, sum_y, lo_y, hi_y;
    logic [ADDR_W-1:0] start_base;
    logic              trigger;
    logic              accept;

    // Clipping compares before subtracting so a brush near the top/left edge never wraps.
    always_comb begin
        clamp_x    = (cursor_loc_x > X_MAX) ? X_MAX : cursor_loc_x;
        clamp_y    = (cursor_loc_y > Y_MAX) ? Y_MAX : cursor_loc_y;
        wide_x     = {7'd0, stroke_width};
        wide_y     = {6'd0, stroke_width};
        lo_x       = (clamp_x >= wide_x) ? (clamp_x - wide_x) : '0;
        lo_y       = (clamp_y >= wide_y) ? (clamp_y - wide_y) : '0;
        sum_x      = clamp_x + wide_x;
        sum_y      = clamp_y + wide_y;
        hi_x       = (sum_x > X_MAX) ? X_MAX : sum_x;
        hi_y       = (sum_y > Y_MAX) ? Y_MAX : sum_y;
        start_base = ADDR_W'(lo_y) * ROW_STEP;
        trigger    = pen_down_in && (!snap_valid ||
                     (cursor_loc_x != snap_x) || (cursor_loc_y != snap_y) ||
                     (cursor_color != snap_color) || (stroke_width != snap_w));
        accept     = fb_valid_out && fb_ready_in;
    end

    // Write port: a beat transfers on a cycle where fb_valid_out && fb_ready_in; while
    // fb_valid_out is high and fb_ready_in is low, address and data hold unchanged.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state           <= S_IDLE;
            snap_x          <= '0;
            snap_y          <= '0;
            snap_color      <= '0;
            snap_w          <= '0;
            snap_valid      <= 1'b0;
            clear_pending   <= 1'b0;
            box_x0          <= '0;
            box_x1          <= '0;
            box_y1          <= '0;
            cur_x           <= '0;
            cur_y           <= '0;
            row_base        <= '0;
            fb_addr_out     <= '0;
            fb_data_out     <= '0;
            fb_valid_out    <= 1'b0;
            busy_out        <= 1'b0;
            stroke_done_out <= 1'b0;
        end else begin
            stroke_done_out <= 1'b0;
            if (clear_in) clear_pending <= 1'b1;
            if (!pen_down_in) snap_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (clear_pending) begin
                        clear_pending <= clear_in;
                        fb_addr_out   <= '0;
                        fb_data_out   <= '0;
                        fb_valid_out  <= 1'b1;
                        busy_out      <= 1'b1;
                        state         <= S_CLEAR;
                    end else if (trigger) begin
                        snap_x       <= cursor_loc_x;
                        snap_y       <= cursor_loc_y;
                        snap_color   <= cursor_color;
                        snap_w       <= stroke_width;
                        snap_valid   <= 1'b1;
                        box_x0       <= lo_x;
                        box_x1       <= hi_x;
                        box_y1       <= hi_y;
                        cur_x        <= lo_x;
                        cur_y        <= lo_y;
                        row_base     <= start_base;
                        fb_addr_out  <= start_base + ADDR_W'(lo_x);
                        fb_data_out  <= cursor_color;
                        fb_valid_out <= 1'b1;
                        busy_out     <= 1'b1;
                        state        <= S_PAINT;
                    end
                end

                S_PAINT: begin
                    if (accept) begin
                        if (cur_x == box_x1) begin
                            if (cur_y == box_y1) begin
                                fb_valid_out    <= 1'b0;
                                busy_out        <= 1'b0;
                                stroke_done_out <= 1'b1;
                                state           <= S_IDLE;
                            end else begin
                                cur_y       <= cur_y + 9'd1;
                                cur_x       <= box_x0;
                                row_base    <= row_base + ROW_STEP;
                                fb_addr_out <= row_base + ROW_STEP + ADDR_W'(box_x0);
                            end
                        end else begin
                            cur_x       <= cur_x + 10'd1;
                            fb_addr_out <= row_base + ADDR_W'(cur_x + 10'd1);
                        end
                    end
                end

                S_CLEAR: begin
                    if (accept) begin
                        if (fb_addr_out == LAST_ADDR) begin
                            // Forget the snapshot so a held pen repaints over the cleared screen.
                            snap_valid      <= 1'b0;
                            fb_valid_out    <= 1'b0;
                            busy_out        <= 1'b0;
                            stroke_done_out <= 1'b1;
                            state           <= S_IDLE;
                        end else begin
                            fb_addr_out <= fb_addr_out + ADDR_W'(1);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stroke_painter.sv
// Bench for stroke_painter: full-size instance for strokes, small-screen instance for clear.
// Accepted writes are captured and compared with a pixel-list model of the brush rules.
module tb_stroke_painter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [9:0]  cx = '0;
    logic [8:0]  cy = '0;
    logic [3:0]  cc = '0;
    logic [2:0]  cw = '0;
    logic        pen_a = 1'b0, pen_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
    logic        ready = 1'b1;
    int          ready_mode = 0;

    logic [17:0] addr_a;
    logic [3:0]  data_a;
    logic        valid_a, busy_a, done_a;
    logic [9:0]  addr_b;
    logic [3:0]  data_b;
    logic        valid_b, busy_b, done_b;

    stroke_painter dut_a (
        .clk_in(clk), .rst_in(rst_n),
        .cursor_loc_x(cx), .cursor_loc_y(cy), .cursor_color(cc), .stroke_width(cw),
        .pen_down_in(pen_a), .clear_in(clr_a),
        .fb_addr_out(addr_a), .fb_data_out(data_a), .fb_valid_out(valid_a),
        .fb_ready_in(ready), .busy_out(busy_a), .stroke_done_out(done_a)
    );

    stroke_painter #(.H_RES(40), .V_RES(24), .ADDR_W(10)) dut_b (
        .clk_in(clk), .rst_in(rst_n),
        .cursor_loc_x(cx), .cursor_loc_y(cy), .cursor_color(cc), .stroke_width(cw),
        .pen_down_in(pen_b), .clear_in(clr_b),
        .fb_addr_out(addr_b), .fb_data_out(data_b), .fb_valid_out(valid_b),
        .fb_ready_in(ready), .busy_out(busy_b), .stroke_done_out(done_b)
    );

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_q[$];
    logic [21:0] got_a[$];
    logic [21:0] got_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, got_at_done_a = 0;
    int stall_viol_a = 0, stall_viol_b = 0, long_done_a = 0, long_done_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0, prev_done_a = 1'b0, prev_done_b = 1'b0;
    logic [21:0] held_a = '0, held_b = '0;

    // Ready pattern: 0 = always high, 1 = alternating, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Capture accepted writes and protocol events, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_a && ready) got_a.push_back({addr_a, data_a});
        if (hold_a && valid_a && ({addr_a, data_a} != held_a)) stall_viol_a++;
        hold_a = valid_a && !ready;
        held_a = {addr_a, data_a};
        if (done_a) begin
            done_cnt_a++;
            got_at_done_a = got_a.size();
            if (prev_done_a) long_done_a++;
        end
        prev_done_a = done_a;

        if (valid_b && ready) got_b.push_back({8'd0, addr_b, data_b});
        if (hold_b && valid_b && ({8'd0, addr_b, data_b} != held_b)) stall_viol_b++;
        hold_b = valid_b && !ready;
        held_b = {8'd0, addr_b, data_b};
        if (done_b) begin
            done_cnt_b++;
            if (prev_done_b) long_done_b++;
        end
        prev_done_b = done_b;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    // Brush model: every pixel of the (2w+1)^2 square around the clamped cursor that lies on screen.
    task automatic model_stroke(input int x, input int y, input int c, input int w,
                                input int hres, input int vres);
        int xc, yc;
        xc = (x > hres - 1) ? hres - 1 : x;
        yc = (y > vres - 1) ? vres - 1 : y;
        for (int yy = yc - w; yy <= yc + w; yy++) begin
            for (int xx = xc - w; xx <= xc + w; xx++) begin
                if (yy >= 0 && yy < vres && xx >= 0 && xx < hres)
                    exp_q.push_back({18'(yy * hres + xx), 4'(c)});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pen_a = 1'b0; pen_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_a.delete(); got_b.delete(); exp_q.delete();
        done_cnt_a = 0; done_cnt_b = 0; got_at_done_a = 0;
        hold_a = 1'b0; hold_b = 1'b0;
    endtask

    task automatic set_cursor(input int x, input int y, input int c, input int w);
        cx = 10'(x); cy = 9'(y); cc = 4'(c); cw = 3'(w);
    endtask

    task automatic wait_done(input bit sel, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if ((sel ? done_cnt_b : done_cnt_a) >= target) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_a); end
        checks++; if (addr_a !== 18'd0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", addr_a); end
        checks++; if (data_a !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d, expected 0", data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_a); end
        checks++; if (valid_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_small: got valid=%b busy=%b, expected 0 0", valid_b, busy_b); end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        int shown = 0;
        do_reset();
        set_cursor(100, 50, 5, 0);
        pen_a = 1'b1;
        wait_done(1'b0, 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no done pulse, expected one within 100 cycles"); end
        repeat (20) @(posedge clk);
        model_stroke(100, 50, 5, 0, 640, 360);
        checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d writes, expected %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_q[i]) begin
                errors++;
                if (shown++ < 4) $display("FAIL single_pixel[%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, got_a[i][21:4], got_a[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
            end
        end
        checks++; if (got_a.size() > 0 && got_a[0][21:4] !== 18'd32100) begin errors++; $display("FAIL single_addr: got %0d, expected 32100", got_a[0][21:4]); end
        checks++; if (done_cnt_a != 1) begin errors++; $display("FAIL single_done_count: got %0d, expected 1", done_cnt_a); end
    endtask

    task automatic test_timing();
        int shown = 0;
        do_reset();
        set_cursor(0, 0, 3, 2);
        pen_a = 1'b1;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL timing_pre_valid: got %b, expected 0", valid_a); end
        @(negedge clk);
        checks++; if (valid_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL timing_first: got valid=%b busy=%b, expected 1 1", valid_a, busy_a); end
        checks++; if (addr_a !== 18'd0 || data_a !== 4'd3) begin errors++; $display("FAIL timing_first_pixel: got addr=%0d data=%0d, expected 0 3", addr_a, data_a); end
        repeat (8) @(negedge clk);
        checks++; if (valid_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL timing_last_pixel: got valid=%b done=%b, expected 1 0", valid_a, done_a); end
        @(negedge clk);
        checks++; if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL timing_done: got done=%b valid=%b busy=%b, expected 1 0 0", done_a, valid_a, busy_a); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL timing_done_width: got %b, expected 0", done_a); end
        repeat (10) @(posedge clk);
        model_stroke(0, 0, 3, 2, 640, 360);
        checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL timing_count: got %0d writes, expected %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_q[i]) begin
                errors++;
                if (shown++ < 4) $display("FAIL timing_pixel[%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, got_a[i][21:4], got_a[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int shown = 0;
        do_reset();
        ready_mode = 1;
        set_cursor(0, 0, 3, 2);
        pen_a = 1'b1;
        wait_done(1'b0, 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done pulse, expected one within 100 cycles"); end
        repeat (10) @(posedge clk);
        ready_mode = 0;
        model_stroke(0, 0, 3, 2, 640, 360);
        checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d writes, expected %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_q[i]) begin
                errors++;
                if (shown++ < 4) $display("FAIL stall_pixel[%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, got_a[i][21:4], got_a[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
            end
        end
        checks++; if (stall_viol_a != 0) begin errors++; $display("FAIL stall_hold: got %0d changes during stalls, expected 0", stall_viol_a); end
        checks++; if (got_at_done_a != 9) begin errors++; $display("FAIL stall_done_after: got done after %0d writes, expected 9", got_at_done_a); end
        checks++; if (done_cnt_a != 1) begin errors++; $display("FAIL stall_done_count: got %0d, expected 1", done_cnt_a); end
    endtask

    task automatic test_random_strokes();
        bit ok;
        int shown = 0;
        int x, y, w, c, target;
        do_reset();
        ready_mode = 2;
        x = 639; y = 359; w = 7; c = 9;
        for (int iter = 0; iter < 8; iter++) begin
            got_a.delete();
            exp_q.delete();
            target = done_cnt_a + 1;
            set_cursor(x, y, c, w);
            pen_a = 1'b1;
            wait_done(1'b0, target, 800, ok);
            checks++; if (!ok) begin errors++; $display("FAIL random_timeout[%0d]: got no done pulse, expected one within 800 cycles", iter); end
            repeat (15) @(posedge clk);
            model_stroke(x, y, c, w, 640, 360);
            checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL random_count[%0d]: got %0d writes, expected %0d", iter, got_a.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
                checks++;
                if (got_a[i] !== exp_q[i]) begin
                    errors++;
                    if (shown++ < 4) $display("FAIL random_pixel[%0d/%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", iter, i, got_a[i][21:4], got_a[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
                end
            end
            if (iter == 0) begin
                checks++; if (got_a.size() == 64 && (got_a[0][21:4] !== 18'd225912 || got_a[63][21:4] !== 18'd230399)) begin errors++; $display("FAIL corner_ends: got first=%0d last=%0d, expected 225912 230399", got_a[0][21:4], got_a[63][21:4]); end
            end
            x = $urandom_range(0, 700);
            y = $urandom_range(0, 400);
            w = $urandom_range(0, 7);
            c = (c + $urandom_range(1, 15)) % 16;
        end
        ready_mode = 0;
        checks++; if (stall_viol_a != 0) begin errors++; $display("FAIL random_hold: got %0d changes during stalls, expected 0", stall_viol_a); end
        checks++; if (long_done_a != 0) begin errors++; $display("FAIL random_done_width: got %0d long pulses, expected 0", long_done_a); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int shown = 0;
        int target;
        do_reset();
        ready_mode = 0;
        set_cursor(639, 359, 6, 7);
        pen_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (got_a.size() >= 10) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid_progress: got %0d writes, expected at least 10", got_a.size()); end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_a.delete();
        target = done_cnt_a + 1;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_mid_outputs: got valid=%b busy=%b, expected 0 0", valid_a, busy_a); end
        wait_done(1'b0, target, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid_timeout: got no done pulse, expected one within 200 cycles"); end
        repeat (5) @(posedge clk);
        model_stroke(639, 359, 6, 7, 640, 360);
        checks++; if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL reset_mid_count: got %0d writes, expected %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_q[i]) begin
                errors++;
                if (shown++ < 4) $display("FAIL reset_mid_pixel[%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, got_a[i][21:4], got_a[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
            end
        end
    endtask

    task automatic test_clear_mid_stroke();
        bit ok;
        int shown = 0;
        do_reset();
        ready_mode = 0;
        set_cursor(639, 359, 12, 7);
        pen_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        clr_b = 1'b0;
        wait_done(1'b1, 3, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout: got %0d done pulses, expected 3 within 3000 cycles", done_cnt_b); end
        repeat (10) @(posedge clk);
        model_stroke(639, 359, 12, 7, 40, 24);
        for (int a = 0; a < 40 * 24; a++) exp_q.push_back({18'(a), 4'd0});
        model_stroke(639, 359, 12, 7, 40, 24);
        checks++; if (got_b.size() != exp_q.size()) begin errors++; $display("FAIL clear_count: got %0d writes, expected %0d", got_b.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_q[i]) begin
                errors++;
                if (shown++ < 4) $display("FAIL clear_pixel[%0d]: got addr=%0d data=%0d, expected addr=%0d data=%0d", i, got_b[i][21:4], got_b[i][3:0], exp_q[i][21:4], exp_q[i][3:0]);
            end
        end
        checks++; if (done_cnt_b != 3 || long_done_b != 0) begin errors++; $display("FAIL clear_done: got %0d pulses (%0d long), expected 3 (0 long)", done_cnt_b, long_done_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL clear_busy_end: got %b, expected 0", busy_b); end
        checks++; if (got_a.size() != 0) begin errors++; $display("FAIL clear_isolation: got %0d writes on idle instance, expected 0", got_a.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timing();
        test_stall();
        test_random_strokes();
        test_reset_mid();
        test_clear_mid_stroke();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stroke_painter.md
# stroke_painter

Consumer end of the cursor control path: samples cursor position, color index and stroke width from the user-input block and rasterizes a square brush into the 640x360 4-bit framebuffer through a valid/ready write port. Also performs a full-screen clear on request. Sits between the user-input block and the framebuffer BRAM write arbiter.

## Interface
Parameters:
- H_RES, 640, framebuffer width in pixels
- V_RES, 360, framebuffer height in pixels
- ADDR_W, 18, framebuffer address width (H_RES*V_RES = 230400 < 2^18)

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  synchronous, active-low reset
- cursor_loc_x  input  10  cursor column
- cursor_loc_y  input  9  cursor row
- cursor_color  input  4  brush color index
- stroke_width  input  3  brush half-width w (0..7)
- pen_down_in  input  1  level; painting enabled while high
- clear_in  input  1  single-cycle clear request
- fb_addr_out  output  ADDR_W  pixel address, y*H_RES + x
- fb_data_out  output  4  pixel color
- fb_valid_out  output  1  write request
- fb_ready_in  input  1  write accepted when valid && ready
- busy_out  output  1  high in PAINT or CLEAR
- stroke_done_out  output  1  one-cycle pulse after last pixel of a stroke or clear accepted

## Operation
- States: IDLE, PAINT, CLEAR.
- Snapshot registers hold last painted (x, y, color, w) plus snap_valid flag; snap_valid cleared by reset and by pen_down_in low.
- clear_pending: set by clear_in in any state, cleared on entry to CLEAR.
- IDLE: if clear_pending -> CLEAR (priority). Else if pen_down_in and (!snap_valid or any of x/y/color/w differs from snapshot) -> latch inputs into snapshot, set snap_valid, compute clipped box, -> PAINT.
- Input clamp at latch: x' = min(x, H_RES-1), y' = min(y, V_RES-1).
- Clipped box: x0 = max(0, x'-w), x1 = min(H_RES-1, x'+w), y0 = max(0, y'-w), y1 = min(V_RES-1, y'+w). Subtraction done with sign/underflow check, not wrapping.
- PAINT: row-major scan x0..x1 inner, y0..y1 outer; every scanned pixel emitted with latched color. Address maintained incrementally: row_base += H_RES per row, addr = row_base + x; no multiplier in scan path. Pixel count = (x1-x0+1)*(y1-y0+1), 1..225.
- CLEAR: addresses 0..H_RES*V_RES-1 ascending, data 0. After clear, snap_valid cleared so a held pen repaints current position.
- Input changes during PAINT/CLEAR ignored; re-evaluated in IDLE against snapshot, so the final cursor state is always painted.
- pen_down_in falling during PAINT does not abort the stroke.

## Timing
- Reset values: fb_valid_out 0, fb_addr_out 0, fb_data_out 0, busy_out 0, stroke_done_out 0, state IDLE, snap_valid 0, clear_pending 0.
- All outputs registered.
- Trigger detected in IDLE at cycle N: fb_valid_out and busy_out high at N+1 with first pixel.
- fb_addr_out/fb_data_out stable while fb_valid_out && !fb_ready_in; advance only on acceptance; no drops, no duplicates.
- With fb_ready_in held high: one pixel per cycle; last pixel of a K-pixel stroke accepted at N+K; at N+K+1 fb_valid_out 0, busy_out 0, stroke_done_out 1 for one cycle, state IDLE.
- Earliest next trigger evaluation: cycle N+K+1 (new stroke valid at N+K+2).
- Clear: 230400 accepted writes; same done/busy timing.
- Reset mid-operation: outputs take reset values the cycle after rst_in sampled low; partial stroke abandoned.

## Test plan
- Reset, pen down at (100,50), w=0, color 5, ready=1 -> exactly one write addr 32100 data 5, done pulse, no further writes while inputs static.
- Pen down at (0,0), w=2, color 3 -> 9 writes, addrs 0,1,2,640,641,642,1280,1281,1282, all data 3.
- Pen down at (639,359), w=7 -> 64 writes, x 632..639, y 352..359, first addr 225912, last 230399.
- Repeat case 2 with fb_ready_in alternating 0/1 -> same 9 addrs in order, addr/data held during stalls, done after 9th acceptance.
- clear_in pulsed mid-stroke of case 3 -> stroke finishes (64 writes), then 230400 writes data 0 addrs 0..230399, then held pen repaints (639,359) w=7.
- rst_in low one cycle during case 3 after 10 writes -> fb_valid_out 0 next cycle; after release with pen still down, full 64-pixel stroke restarts from addr 225912.
